// File: rtl/bridge_pixel_fifo.sv
// Bus-bridge slave that buffers packed pixel words in a FIFO and unpacks them
// into a one-pixel-per-cycle valid/ready stream with control/status registers.
module bridge_pixel_fifo #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    bus_enable,
  input  logic                    r_wbar,
  input  logic [BUS_WIDTH-1:0]    write_data,
  input  logic [BUS_WIDTH/8-1:0]  byte_enable,
  output logic [BUS_WIDTH-1:0]    read_data,
  output logic                    ack,
  output logic                    irq,
  output logic [DATA_WIDTH-1:0]   pixel_out,
  output logic                    pixel_valid,
  input  logic                    pixel_ready
);

  localparam int PPW    = BUS_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LW     = PTR_W + 1;
  localparam int CMP_W  = (LW > 8) ? LW : 8;

  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_CLR = ADDR_WIDTH'(3);

  // Bus decode
  logic txn, wr_txn;
  logic wr_data, wr_ctrl, wr_clr;
  logic flush, clr_pending, clr_overflow;

  // FIFO
  logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, drop;

  // Serializer
  logic                 ser_valid;
  logic [BUS_WIDTH-1:0] ser_word;
  logic [LANE_W-1:0]    lane;
  logic                 fire, last_lane, ser_free;

  // Control / status
  logic                 out_en, irq_en;
  logic [7:0]           threshold;
  logic                 overflow, irq_pending;
  logic                 low, low_q, irq_set;
  logic [BUS_WIDTH-1:0] status_word, ctrl_word, rdata_next;

  logic unused_be;
  assign unused_be = &{1'b0, byte_enable};

  assign txn     = bus_enable & ~ack;
  assign wr_txn  = txn & ~r_wbar;
  assign wr_data = wr_txn & (addr == ADDR_DATA);
  assign wr_ctrl = wr_txn & (addr == ADDR_CTRL);
  assign wr_clr  = wr_txn & (addr == ADDR_IRQ_CLR);

  assign flush        = wr_ctrl & byte_enable[0] & write_data[2];
  assign clr_pending  = wr_clr & write_data[0];
  assign clr_overflow = wr_clr & write_data[1];

  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);

  // Full is judged on the pre-edge level, so a push into a full FIFO is
  // dropped even if the serializer pops in the same cycle.
  assign push = wr_data & ~fifo_full;
  assign drop = wr_data & fifo_full;

  assign pixel_valid = ser_valid & out_en;
  assign fire        = pixel_valid & pixel_ready;
  assign last_lane   = (lane == LANE_W'(PPW - 1));
  assign ser_free    = ~ser_valid | (fire & last_lane);
  assign pop         = ser_free & out_en & ~fifo_empty & ~flush;
  assign pixel_out   = ser_word[lane*DATA_WIDTH +: DATA_WIDTH];

  // NOTE: the storage array has no reset; the level/pointer logic alone defines
  // which entries are meaningful, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= write_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Last-lane acceptance and the next load share one edge, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_valid <= 1'b0;
      ser_word  <= '0;
      lane      <= '0;
    end else if (flush) begin
      ser_valid <= 1'b0;
      lane      <= '0;
    end else if (pop) begin
      ser_valid <= 1'b1;
      ser_word  <= mem[rd_ptr];
      lane      <= '0;
    end else if (fire) begin
      if (last_lane) ser_valid <= 1'b0;
      else           lane      <= lane + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en    <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= '0;
    end else if (wr_ctrl) begin
      if (byte_enable[0]) begin
        out_en <= write_data[0];
        irq_en <= write_data[1];
      end
      if (byte_enable[1]) threshold <= write_data[15:8];
    end
  end

  assign low     = (CMP_W'(level) <= CMP_W'(threshold));
  assign irq_set = low & ~low_q;

  // A set wins over a same-cycle clear for both sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q       <= 1'b1;
      irq_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      low_q       <= low;
      irq_pending <= irq_set | (irq_pending & ~clr_pending);
      overflow    <= drop | (overflow & ~clr_overflow);
    end
  end

  assign irq = irq_pending & irq_en;

  always_comb begin
    status_word          = '0;
    status_word[LW-1:0]  = level;
    status_word[16]      = fifo_full;
    status_word[17]      = fifo_empty & ~ser_valid;
    status_word[18]      = overflow;
    status_word[19]      = irq_pending;

    ctrl_word            = '0;
    ctrl_word[0]         = out_en;
    ctrl_word[1]         = irq_en;
    ctrl_word[15:8]      = threshold;

    rdata_next = '0;
    case (addr)
      ADDR_STATUS: rdata_next = status_word;
      ADDR_CTRL:   rdata_next = ctrl_word;
      default:     rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      read_data <= '0;
    end else if (txn) begin
      ack       <= 1'b1;
      read_data <= r_wbar ? rdata_next : '0;
    end else begin
      ack       <= 1'b0;
      read_data <= '0;
    end
  end

endmodule
